uart_tx_fifo: RTL and testbench

Byte-wide transmit buffer that sits directly upstream of the UART transmitter. It accepts bytes from host logic through a valid/ready handshake and stores up to DEPTH bytes. It drains them one at a time into the transmitter's `din`/`wr_en`/`tx_busy` interface and paces each launch so that the next byte is issued only after the current frame completes.

---
 rtl/uart_tx_fifo.sv | 117 +++++++++++
 tb/tb_uart_tx_fifo.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: valid/ready push side, paced single-cycle
// launches on the transmitter side, with a sticky error if busy never answers a launch.
module uart_tx_fifo #(
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic [7:0]        uart_din,
    output logic              uart_wr_en,
    input  logic              uart_tx_busy,
    output logic              tx_active,
    output logic              timeout_err,
    output logic [1:0]        fsm_state
);
    // Handshake: a byte is taken on any rising edge where wr_valid && wr_ready;
    // the host must hold wr_data stable until then.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam int TW = $clog2(BUSY_TIMEOUT) + 1;
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE  = 1;
    localparam logic [TW-1:0]     TMO_ONE  = 1;
    localparam logic [TW-1:0]     TMO_LAST = TW'(BUSY_TIMEOUT - 2);

    state_t            state;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [TW-1:0]     tmo_cnt;
    logic              push;
    logic              pop;

    assign full      = (count == CNT_FULL);
    assign empty     = (count == '0);
    assign wr_ready  = !full;
    assign push      = wr_valid && !full;
    assign pop       = (state == IDLE) && !empty && !uart_tx_busy;
    assign tx_active = (state != IDLE);
    assign fsm_state = state;

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            uart_din    <= 8'h00;
            uart_wr_en  <= 1'b0;
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                count <= count + CNT_ONE;
            end else if (pop && !push) begin
                count <= count - CNT_ONE;
            end

            case (state)
                IDLE: begin
                    if (pop) begin
                        uart_din   <= mem[rd_ptr];
                        uart_wr_en <= 1'b1;
                        rd_ptr     <= rd_ptr + PTR_ONE;
                        state      <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    uart_wr_en <= 1'b0;
                    tmo_cnt    <= '0;
                    state      <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (uart_tx_busy) begin
                        state <= WAIT_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_ONE;
                        // Byte is treated as consumed; draining continues.
                        if (tmo_cnt == TMO_LAST) begin
                            timeout_err <= 1'b1;
                            state       <= IDLE;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (!uart_tx_busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: transmitter busy model, queue-based reference of the
// stored bytes, and per-feature scenario tasks.
module tb_uart_tx_fifo;
    localparam int DEPTH        = 16;
    localparam int ADDR_W       = 4;
    localparam int BUSY_TIMEOUT = 8;
    localparam int CW           = ADDR_W + 1;
    localparam int X_NORMAL     = 0;
    localparam int X_HOLD       = 1;
    localparam int X_LOW        = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        wr_data = 8'h00;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [ADDR_W:0]   count;
    logic              empty;
    logic              full;
    logic [7:0]        uart_din;
    logic              uart_wr_en;
    logic              uart_tx_busy = 1'b0;
    logic              tx_active;
    logic              timeout_err;
    logic [1:0]        fsm_state;

    int checks = 0;
    int failures = 0;
    int xmode = X_NORMAL;
    int frame_len = 100;
    int frame_left = 0;
    bit rand_frames = 1'b0;
    bit mon_en = 1'b0;
    int launches = 0;
    logic [7:0] exp_q[$];
    logic [7:0] launch_log[$];

    uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .count(count), .empty(empty), .full(full), .uart_din(uart_din), .uart_wr_en(uart_wr_en),
        .uart_tx_busy(uart_tx_busy), .tx_active(tx_active), .timeout_err(timeout_err),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    // Transmitter model: busy rises the cycle after a launch pulse and lasts one frame.
    always @(negedge clk) begin
        if (xmode == X_HOLD) begin
            uart_tx_busy = 1'b1;
            frame_left = 0;
        end else if (xmode == X_LOW) begin
            uart_tx_busy = 1'b0;
            frame_left = 0;
        end else begin
            if (uart_wr_en === 1'b1) frame_left = rand_frames ? $urandom_range(2, 12) : frame_len;
            if (frame_left > 0) begin
                uart_tx_busy = 1'b1;
                frame_left--;
            end else begin
                uart_tx_busy = 1'b0;
            end
        end
    end

    // Scoreboard: bytes leave in the order accepted; occupancy flags follow the queue.
    logic       mon_push, mon_rst, mon_busy, mon_prev_en;
    logic [7:0] mon_data, mon_exp;
    always @(posedge clk) begin
        mon_push    = wr_valid && wr_ready;
        mon_rst     = rst;
        mon_busy    = uart_tx_busy;
        mon_prev_en = uart_wr_en;
        mon_data    = wr_data;
        #1;
        if (mon_en) begin
            if (mon_rst) begin
                exp_q.delete();
            end else begin
                if (mon_push) exp_q.push_back(mon_data);
                if (uart_wr_en === 1'b1) begin
                    launches++;
                    launch_log.push_back(uart_din);
                    checks++;
                    if (mon_prev_en !== 1'b0 || mon_busy !== 1'b0) begin
                        failures++;
                        $display("FAIL launch_gap: prev_wr_en=%b busy_at_edge=%b, required 0/0", mon_prev_en, mon_busy);
                    end
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL launch_underflow: launched %h with nothing stored", uart_din);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        if (uart_din !== mon_exp) begin
                            failures++;
                            $display("FAIL din_order: got %h, required %h", uart_din, mon_exp);
                        end
                    end
                end
            end
            checks++;
            if (count !== CW'(exp_q.size()) || empty !== (exp_q.size() == 0) ||
                full !== (exp_q.size() == DEPTH) || wr_ready !== (exp_q.size() != DEPTH)) begin
                failures++;
                $display("FAIL occupancy: count=%0d empty=%b full=%b ready=%b, required count=%0d",
                         count, empty, full, wr_ready, exp_q.size());
            end
        end
    end

    task automatic push_byte(input logic [7:0] d);
        int waited = 0;
        @(negedge clk);
        wr_valid = 1'b1;
        wr_data  = d;
        while (!wr_ready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (!wr_ready) begin
            failures++;
            $display("FAIL push_wait: wr_ready=%b after %0d cycles, required 1", wr_ready, waited);
        end
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            @(posedge clk);
            #2;
            if (!tx_active && !uart_tx_busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_launches(input int target, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #2;
            if (launches >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mon_en = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || wr_ready !== 1'b1 || uart_din !== 8'h00 ||
            uart_wr_en !== 1'b0 || tx_active !== 1'b0 || timeout_err !== 1'b0 || fsm_state !== 2'd0) begin
            failures++;
            $display("FAIL reset_values: cnt=%0d e=%b f=%b rdy=%b din=%h en=%b act=%b err=%b, required 0 1 0 1 00 0 0 0",
                     count, empty, full, wr_ready, uart_din, uart_wr_en, tx_active, timeout_err);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        checks++;
        if (count !== 5'd0 || wr_ready !== 1'b1 || uart_wr_en !== 1'b0 || tx_active !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: cnt=%0d rdy=%b en=%b act=%b, required 0 1 0 0",
                     count, wr_ready, uart_wr_en, tx_active);
        end
    endtask

    task automatic test_single_byte();
        int base = launches;
        bit ok;
        xmode = X_NORMAL;
        frame_len = 100;
        push_byte(8'hA5);
        checks++;
        if (uart_wr_en !== 1'b0 || count !== 5'd1) begin
            failures++;
            $display("FAIL single_push_edge: en=%b cnt=%0d, required 0 1", uart_wr_en, count);
        end
        @(posedge clk);
        #2;
        checks++;
        if (uart_wr_en !== 1'b1 || uart_din !== 8'hA5 || count !== 5'd0) begin
            failures++;
            $display("FAIL single_launch: en=%b din=%h cnt=%0d, required 1 a5 0", uart_wr_en, uart_din, count);
        end
        wait_idle(ok);
        checks++;
        if (!ok || launches != base + 1) begin
            failures++;
            $display("FAIL single_one_pulse: idle=%b pulses=%0d, required 1 1", ok, launches - base);
        end
    endtask

    task automatic test_fill_backpressure();
        int base = launches;
        bit ok;
        xmode = X_HOLD;
        for (int i = 0; i < DEPTH; i++) push_byte(8'(i));
        checks++;
        if (full !== 1'b1 || count !== 5'd16 || wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL fill_full: full=%b cnt=%0d rdy=%b, required 1 16 0", full, count, wr_ready);
        end
        @(negedge clk);
        wr_valid = 1'b1;
        wr_data  = 8'h10;
        repeat (4) @(posedge clk);
        #2;
        checks++;
        if (count !== 5'd16 || wr_ready !== 1'b0 || uart_wr_en !== 1'b0) begin
            failures++;
            $display("FAIL fill_hold: cnt=%0d rdy=%b en=%b, required 16 0 0", count, wr_ready, uart_wr_en);
        end
        frame_len = 3;
        xmode = X_NORMAL;
        for (int n = 0; n < 100 && !wr_ready; n++) @(negedge clk);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        wait_launches(base + DEPTH + 1, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL fill_drain: launches=%0d, required %0d", launches - base, DEPTH + 1);
        end
        for (int i = 0; i <= DEPTH && ok; i++) begin
            checks++;
            if (launch_log[base + i] !== 8'(i)) begin
                failures++;
                $display("FAIL fill_order: launch %0d got %h, required %h", i, launch_log[base + i], 8'(i));
            end
        end
        wait_idle(ok);
    endtask

    task automatic test_push_pop_same_edge();
        int base = launches;
        bit ok;
        xmode = X_HOLD;
        push_byte(8'h3C);
        repeat (3) @(posedge clk);
        #1;
        xmode = X_NORMAL;
        push_byte(8'hC3);
        checks++;
        if (count !== 5'd1 || uart_wr_en !== 1'b1 || uart_din !== 8'h3C) begin
            failures++;
            $display("FAIL simul_edge: cnt=%0d en=%b din=%h, required 1 1 3c", count, uart_wr_en, uart_din);
        end
        wait_launches(base + 2, ok);
        checks++;
        if (!ok || launch_log[base + 1] !== 8'hC3) begin
            failures++;
            $display("FAIL simul_order: done=%b second=%h, required 1 c3", ok, ok ? launch_log[base + 1] : 8'h00);
        end
        wait_idle(ok);
    endtask

    task automatic test_timeout();
        int base = launches;
        int k = 0;
        int first = 0;
        bit ok;
        xmode = X_LOW;
        push_byte(8'h5A);
        for (int n = 0; n < 4; n++) begin
            if (uart_wr_en === 1'b1) break;
            @(posedge clk);
            #2;
            k++;
        end
        checks++;
        if (uart_wr_en !== 1'b1 || k != 1) begin
            failures++;
            $display("FAIL timeout_launch: en=%b latency=%0d, required 1 1", uart_wr_en, k);
        end
        for (int j = 1; j <= 12; j++) begin
            @(posedge clk);
            #2;
            if (timeout_err === 1'b1 && first == 0) begin
                first = j;
                checks++;
                if (tx_active !== 1'b0) begin
                    failures++;
                    $display("FAIL timeout_idle: tx_active=%b, required 0", tx_active);
                end
            end
        end
        checks++;
        if (first != BUSY_TIMEOUT) begin
            failures++;
            $display("FAIL timeout_rise: err rose %0d cycles after launch, required %0d", first, BUSY_TIMEOUT);
        end
        push_byte(8'h11);
        push_byte(8'h22);
        wait_launches(base + 3, ok);
        wait_idle(ok);
        checks++;
        if (launches != base + 3 || timeout_err !== 1'b1 || count !== 5'd0) begin
            failures++;
            $display("FAIL timeout_continue: launches=%0d err=%b cnt=%0d, required 3 1 0",
                     launches - base, timeout_err, count);
        end
    endtask

    task automatic test_mid_reset();
        int base;
        bit ok = 1'b0;
        xmode = X_NORMAL;
        frame_len = 100;
        for (int i = 0; i < 6; i++) push_byte(8'hE0 + 8'(i));
        for (int n = 0; n < 20; n++) begin
            if (fsm_state === 2'd3) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #2;
        end
        checks++;
        if (!ok || count !== 5'd5) begin
            failures++;
            $display("FAIL midrst_setup: wait_done=%b cnt=%0d, required 1 5", ok, count);
        end
        base = launches;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;
        checks++;
        if (count !== 5'd0 || tx_active !== 1'b0 || uart_wr_en !== 1'b0 || empty !== 1'b1 || timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL midrst_edge: cnt=%0d act=%b en=%b empty=%b err=%b, required 0 0 0 1 0",
                     count, tx_active, uart_wr_en, empty, timeout_err);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (200) @(posedge clk);
        #2;
        checks++;
        if (launches != base) begin
            failures++;
            $display("FAIL midrst_discard: %0d launches after reset, required 0", launches - base);
        end
    endtask

    task automatic test_random_traffic();
        int base = launches;
        int n_acc = 0;
        int rate = 50;
        bit acc;
        bit ok;
        rand_frames = 1'b1;
        xmode = X_NORMAL;
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 0) rate = $urandom_range(5, 95);
            @(negedge clk);
            if (!wr_valid && $urandom_range(0, 99) < rate) begin
                wr_valid = 1'b1;
                wr_data  = 8'($urandom);
            end
            acc = wr_valid && wr_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                n_acc++;
                wr_valid = 1'b0;
            end
        end
        wr_valid = 1'b0;
        wait_launches(base + n_acc, ok);
        wait_idle(ok);
        checks++;
        if (launches != base + n_acc || count !== 5'd0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL random_drain: launches=%0d cnt=%0d empty=%b, required %0d 0 1",
                     launches - base, count, empty, n_acc);
        end
        rand_frames = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_fill_backpressure();
        test_push_pop_same_edge();
        test_timeout();
        test_mid_reset();
        test_random_traffic();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
